// File: rtl/sram_ctrl.sv
// sram_ctrl: async-SRAM controller with wait states, write data hold and read-to-write turnaround
module sram_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter int TURNAROUND  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] chip_addr,
  inout  wire  [DATA_W-1:0] chip_data,
  output logic              not_ce,
  output logic              not_oe,
  output logic              not_we
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;
  state_t state, state_n;
  logic [3:0] wcnt;
  logic [1:0] tcnt;
  logic wr, wr_n, drive, accept;
  logic [DATA_W-1:0] wdata;
  assign req_ready = (state == IDLE) && (tcnt == 2'd0 || !req_write);
  assign accept    = req_valid && req_ready;
  assign chip_data = drive ? wdata : 'z;
  always_comb begin
    state_n = state;
    wr_n    = accept ? req_write : wr;
    state_n = state == IDLE   ? (accept ? SETUP : IDLE) :
              state == SETUP  ? ACCESS :
              state == ACCESS ? (wcnt == 4'd0 ? HOLD : ACCESS) : IDLE;
  end
  // strobes are registered from the next state so they never glitch
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wcnt       <= 4'd0;
      tcnt       <= 2'd0;
      wr         <= 1'b0;
      wdata      <= '0;
      chip_addr  <= '0;
      resp_rdata <= '0;
      resp_valid <= 1'b0;
      not_ce     <= 1'b1;
      not_oe     <= 1'b1;
      not_we     <= 1'b1;
      drive      <= 1'b0;
    end else begin
      state <= state_n;
      wr    <= wr_n;
      if (accept) begin
        chip_addr <= req_addr;
        wdata     <= req_wdata;
      end
      wcnt <= state == ACCESS ? wcnt - 4'd1 : 4'(WAIT_STATES);
      tcnt <= (state == HOLD && !wr) ? 2'(TURNAROUND) :
              (state == IDLE && tcnt != 2'd0) ? tcnt - 2'd1 : tcnt;
      if (state == ACCESS && wcnt == 4'd0 && !wr) resp_rdata <= chip_data;
      resp_valid <= state_n == HOLD;
      not_ce     <= state_n == IDLE;
      not_we     <= !(state_n == ACCESS && wr_n);
      not_oe     <= !(state_n == ACCESS && !wr_n);
      drive      <= state_n != IDLE && wr_n;
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three controller configurations against SRAM models and a reference memory
module tb_sram_ctrl;
  localparam int WSL [3] = '{1, 0, 3};
  localparam int TAL [3] = '{2, 1, 0};
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic        req_valid [3], req_write [3], req_ready [3], resp_valid [3];
  logic        not_ce [3], not_oe [3], not_we [3];
  logic [15:0] req_addr [3], req_wdata [3], resp_rdata [3], chip_addr [3];
  logic [15:0] ref_mem [3][256];
  int checks = 0;
  int errors = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire  [15:0] d;
    logic [15:0] mem [256];
    sram_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(WSL[g]), .TURNAROUND(TAL[g])) u (
      .clk(clk), .reset(reset), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_write(req_write[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .resp_valid(resp_valid[g]), .resp_rdata(resp_rdata[g]), .chip_addr(chip_addr[g]),
      .chip_data(d), .not_ce(not_ce[g]), .not_oe(not_oe[g]), .not_we(not_we[g]));
    assign d = (!not_ce[g] && !not_oe[g]) ? mem[chip_addr[g][7:0]] : 'z;
    always @(posedge clk) if (!not_ce[g] && !not_we[g]) mem[chip_addr[g][7:0]] <= d;
  end
  function automatic logic [15:0] bus(input int k);
    return k == 0 ? g_dut[0].d : k == 1 ? g_dut[1].d : g_dut[2].d;
  endfunction
  // an undriven bus reads as Z, or as 0 on two-state simulators
  function automatic logic off(input int k);
    logic [15:0] v;
    v = bus(k);
    return v === 16'hzzzz || v === 16'h0000;
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle_chk(input int k);
    chk("idle_ce", 16'(not_ce[k]), 16'd1);
    chk("idle_oe", 16'(not_oe[k]), 16'd1);
    chk("idle_we", 16'(not_we[k]), 16'd1);
    chk("idle_bus", 16'(off(k)), 16'd1);
    chk("idle_resp", 16'(resp_valid[k]), 16'd0);
  endtask
  task automatic op(input int k, input bit w, input logic [15:0] a, input logic [15:0] dat,
                    output logic [15:0] rd, output int waits);
    int len;
    len = 3 + WSL[k];
    req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = dat;
    waits = 0;
    #1;
    while (!req_ready[k] && waits < 40) begin @(posedge clk); #1; waits++; end
    chk("accept_timeout", 16'(waits < 40), 16'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_write[k] = 1'($urandom);
    req_addr[k] = 16'($urandom); req_wdata[k] = 16'($urandom);
    if (w) ref_mem[k][a[7:0]] = dat;
    for (int c = 1; c <= len; c++) begin
      bit acc;
      acc = c >= 2 && c <= len - 1;
      chk("not_ce", 16'(not_ce[k]), 16'd0);
      chk("not_we", 16'(not_we[k]), 16'(!(w && acc)));
      chk("not_oe", 16'(not_oe[k]), 16'(!(!w && acc)));
      chk("strobe_overlap", 16'(not_we[k] | not_oe[k]), 16'd1);
      chk("chip_addr", chip_addr[k], a);
      chk("resp_valid", 16'(resp_valid[k]), 16'(c == len));
      if (w) chk("bus_write", bus(k), dat);
      else if (not_oe[k]) chk("bus_off", 16'(off(k)), 16'd1);
      if (c < len) begin @(posedge clk); #1; end
    end
    rd = resp_rdata[k];
    if (!w) chk("rdata", rd, ref_mem[k][a[7:0]]);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [15:0] rd, a;
    logic [15:0] addrs [$];
    int wt;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      idle_chk(k);
      chk("rst_ready", 16'(req_ready[k]), 16'd1);
      chk("rst_rdata", resp_rdata[k], 16'd0);
      chk("rst_addr", chip_addr[k], 16'd0);
    end
    reset = 1'b0;
    op(0, 1'b1, 16'h1234, 16'h00A5, rd, wt);
    op(0, 1'b0, 16'h1234, 16'h0000, rd, wt);
    chk("readback", rd, 16'h00A5);
    req_valid[0] = 1'b1; req_write[0] = 1'b0;
    @(posedge clk); #1;
    chk("read_not_blocked", 16'(req_ready[0]), 16'd1);
    op(0, 1'b0, 16'h1234, 16'h0000, rd, wt);
    chk("read_waits", 16'(wt), 16'd0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0042;
    for (int i = 1; i <= TAL[0] + 1; i++) begin
      @(posedge clk); #1;
      chk("turnaround_ready", 16'(req_ready[0]), 16'(i > TAL[0]));
    end
    op(0, 1'b1, 16'h0042, 16'h3C5A, rd, wt);
    chk("turnaround_waits", 16'(wt), 16'd0);
    for (int k = 1; k < 3; k++) begin
      addrs.delete();
      for (int i = 0; i < 64; i++) begin
        a = 16'($urandom);
        addrs.push_back(a);
        op(k, 1'b1, a, 16'($urandom), rd, wt);
        if (i > 0) chk("b2b_write_waits", 16'(wt), 16'd1);
      end
      for (int i = 0; i < 64; i++) begin
        op(k, 1'b0, addrs[$urandom_range(63)], 16'h0000, rd, wt);
        if (i > 0) chk("b2b_read_waits", 16'(wt), 16'd1);
      end
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0077; req_wdata[0] = 16'hBEEF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("midwrite_we", 16'(not_we[0]), 16'd0);
    reset = 1'b1;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    idle_chk(0);
    chk("midwrite_ready", 16'(req_ready[0]), 16'd1);
    @(posedge clk); #1;
    chk("reset_wins", 16'(not_ce[0]), 16'd1);
    reset = 1'b0;
    req_valid[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      idle_chk(0);
    end
    op(0, 1'b0, 16'h1234, 16'h0000, rd, wt);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req_write[0] = 1'b1;
    #1;
    chk("reset_clears_turnaround", 16'(req_ready[0]), 16'd1);
    chk("reset_rdata", resp_rdata[0], 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
